// File: rtl/mux_scan_pkg.sv
// Shared types for the scanning channel multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan sequencer: dwell counter plus channel pointer, flags the last->0 step.
// Latency: ptr/wrap update on the edge where run is sampled; wrap is high the cycle after ptr returns to 0's edge.
// Backpressure: none; the counter advances every cycle that run is high.
module mux_scan_ctr #(
    parameter int N_CH    = 4,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   ptr,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [DWELL_W-1:0] cnt;

    // Count dwell cycles; the counter wraps modulo 2^DWELL_W so a lowered dwell still matches eventually.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            ptr  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            ptr  <= '0;
            wrap <= 1'b0;
        end else if (run) begin
            if (cnt == dwell) begin
                cnt  <= '0;
                ptr  <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
                wrap <= (ptr == LAST_CH);
            end else begin
                cnt  <= cnt + 1'b1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select or dwell-timed channel scan.
// Latency: 1 cycle from sel/din (or scan pointer) to dout/ch_out/valid.
// Backpressure: none; the consumer must take dout every cycle, valid marks live data.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = 8,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic [N_CH*W-1:0]   din,
    output logic [W-1:0]        dout,
    output logic [SEL_W-1:0]    ch_out,
    output logic                valid,
    output logic                wrap
);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic               ctr_wrap;
    logic [W-1:0]       man_dat;
    logic [W-1:0]       scan_dat;
    logic               man_ok;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: enable dominates, then mode picks manual or scan with no idle gap.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    if (en) state_nxt = (mode == MODE_SCAN) ? SCAN : MANUAL;
            MANUAL:  if (en) state_nxt = (mode == MODE_SCAN) ? SCAN : MANUAL;
            SCAN:    if (en) state_nxt = (mode == MODE_MANUAL) ? MANUAL : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // The pointer only runs while scanning; any other state restarts it at channel 0.
    mux_scan_ctr #(
        .N_CH    (N_CH),
        .DWELL_W (DWELL_W),
        .SEL_W   (SEL_W)
    ) u_scan_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_nxt != SCAN),
        .run   (state_nxt == SCAN),
        .dwell (dwell),
        .ptr   (ptr),
        .wrap  (ctr_wrap)
    );

    // Channel pick for both sources; an out-of-range select yields zero data and no valid.
    always_comb begin
        man_dat  = '0;
        scan_dat = '0;
        man_ok   = (int'(sel) < N_CH);
        for (int k = 0; k < N_CH; k++) begin
            if (int'(sel) == k) man_dat  = din[k*W +: W];
            if (int'(ptr) == k) scan_dat = din[k*W +: W];
        end
    end

    // Output register acts on the state being entered, so mode changes land on the sampling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            ch_out <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            case (state_nxt)
                MANUAL: begin
                    dout   <= man_ok ? man_dat : '0;
                    ch_out <= sel;
                    valid  <= man_ok;
                    wrap   <= 1'b0;
                end
                SCAN: begin
                    dout   <= scan_dat;
                    ch_out <= ptr;
                    valid  <= 1'b1;
                    wrap   <= ctr_wrap;
                end
                default: begin
                    dout   <= '0;
                    valid  <= 1'b0;
                    wrap   <= 1'b0;
                end
            endcase
        end
    end

endmodule
